// File: rtl/ha_lane_sched_pkg.sv
// Shared types and constants for the ha_lane_sched round-robin lane scheduler.
package ha_lane_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic SRC_E = 1'b0;
  localparam logic SRC_F = 1'b1;

  localparam int STAT_W = 16;

endpackage

// File: rtl/ha_lane_sched_ha_lane.sv
// One combinational half-adder lane.
module ha_lane (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/ha_lane_sched.sv
// Round-robin scheduler sharing LANES half-adder lanes between requesters E and F.
// Optional grant/stall counters are enabled by defining HA_LANE_SCHED_STATS_EN.
module ha_lane_sched
  import ha_lane_sched_pkg::*;
#(
  parameter int LANES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e_valid,
  input  logic [LANES-1:0] e_x,
  input  logic [LANES-1:0] e_y,
  output logic             e_ready,
  input  logic             f_valid,
  input  logic [LANES-1:0] f_x,
  input  logic [LANES-1:0] f_y,
  output logic             f_ready,
  output logic             out_valid,
  output logic [LANES-1:0] out_s,
  output logic [LANES-1:0] out_c,
  output logic             out_src,
`ifdef HA_LANE_SCHED_STATS_EN
  output logic [STAT_W-1:0] stat_e_grants,
  output logic [STAT_W-1:0] stat_f_grants,
  output logic [STAT_W-1:0] stat_stall,
`endif
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic             last_src_q;
  logic [LANES-1:0] out_s_q, out_c_q;
  logic             out_src_q;

  logic             can_accept;
  logic             grant_e, grant_f, grant;
  logic [LANES-1:0] op_x, op_y, lane_s, lane_c;

  // On contention the winner is the requester that did not win last time.
  assign can_accept = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
  assign grant_e    = can_accept & e_valid & (~f_valid | (last_src_q == SRC_F));
  assign grant_f    = can_accept & f_valid & (~e_valid | (last_src_q == SRC_E));
  assign grant      = grant_e | grant_f;

  assign e_ready = grant_e & rst_n;
  assign f_ready = grant_f & rst_n;

  assign op_x = grant_f ? f_x : e_x;
  assign op_y = grant_f ? f_y : e_y;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ha_lane u_lane (
      .x (op_x[i]),
      .y (op_y[i]),
      .s (lane_s[i]),
      .c (lane_c[i])
    );
  end

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (out_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_src_q <= SRC_F;
      out_s_q    <= '0;
      out_c_q    <= '0;
      out_src_q  <= SRC_E;
    end else begin
      state_q <= state_d;
      if (grant) begin
        out_s_q    <= lane_s;
        out_c_q    <= lane_c;
        out_src_q  <= grant_f ? SRC_F : SRC_E;
        last_src_q <= grant_f ? SRC_F : SRC_E;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_s     = out_s_q;
  assign out_c     = out_c_q;
  assign out_src   = out_src_q;

`ifdef HA_LANE_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_e_q, stat_f_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_e_q     <= '0;
      stat_f_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      if (grant_e && (stat_e_q != '1)) stat_e_q <= stat_e_q + STAT_W'(1);
      if (grant_f && (stat_f_q != '1)) stat_f_q <= stat_f_q + STAT_W'(1);
      if ((state_q == FULL) && !out_ready && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + STAT_W'(1);
    end
  end

  assign stat_e_grants = stat_e_q;
  assign stat_f_grants = stat_f_q;
  assign stat_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_ha_lane_sched.sv
// Self-checking bench for ha_lane_sched: directed scenarios plus randomized traffic against a reference model.
module tb_ha_lane_sched;

  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         e_valid, f_valid, out_ready;
  logic [L-1:0] e_x, e_y, f_x, f_y;
  logic         e_ready, f_ready, out_valid, out_src;
  logic [L-1:0] out_s, out_c;
`ifdef HA_LANE_SCHED_STATS_EN
  logic [15:0]  stat_e_grants, stat_f_grants, stat_stall;
`endif

  always #5 clk = ~clk;

  ha_lane_sched #(.LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e_valid   (e_valid),
    .e_x       (e_x),
    .e_y       (e_y),
    .e_ready   (e_ready),
    .f_valid   (f_valid),
    .f_x       (f_x),
    .f_y       (f_y),
    .f_ready   (f_ready),
    .out_valid (out_valid),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_src   (out_src),
`ifdef HA_LANE_SCHED_STATS_EN
    .stat_e_grants (stat_e_grants),
    .stat_f_grants (stat_f_grants),
    .stat_stall    (stat_stall),
`endif
    .out_ready (out_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the result register should hold and who won last.
  logic         m_valid, m_src, m_last;
  logic [L-1:0] m_s, m_c;
  int           m_stat_e, m_stat_f, m_stat_stall;

  task automatic model_reset();
    m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1;
    m_s = '0; m_c = '0;
    m_stat_e = 0; m_stat_f = 0; m_stat_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    e_valid = 1'b1; f_valid = 1'b1; out_ready = 1'b1;
    e_x = '0; e_y = '0; f_x = '0; f_y = '0;
    #1;
    check("rst_e_ready", {31'b0, e_ready}, 32'd0);
    check("rst_f_ready", {31'b0, f_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_s", {22'b0, out_s}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    e_valid = 1'b0; f_valid = 1'b0;
  endtask

  // One clock cycle: drive, check readies, clock, check the result register.
  task automatic step(input logic ev, input logic [L-1:0] ex, input logic [L-1:0] ey,
                      input logic fv, input logic [L-1:0] fx, input logic [L-1:0] fy,
                      input logic ordy);
    logic can, ge, gf;
    @(negedge clk);
    e_valid = ev; e_x = ex; e_y = ey;
    f_valid = fv; f_x = fx; f_y = fy;
    out_ready = ordy;
    #1;
    can = !m_valid || ordy;
    if (ev && fv) begin
      ge = can && (m_last == 1'b1);
      gf = can && (m_last == 1'b0);
    end else begin
      ge = can && ev;
      gf = can && fv;
    end
    check("e_ready", {31'b0, e_ready}, {31'b0, ge});
    check("f_ready", {31'b0, f_ready}, {31'b0, gf});
    @(posedge clk);
    if (m_valid && !ordy && m_stat_stall < 65535) m_stat_stall++;
    if (ge && m_stat_e < 65535) m_stat_e++;
    if (gf && m_stat_f < 65535) m_stat_f++;
    if (ge || gf) begin
      m_valid = 1'b1;
      m_src   = gf;
      m_last  = gf;
      m_s     = gf ? (fx ^ fy) : (ex ^ ey);
      m_c     = gf ? (fx & fy) : (ex & ey);
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_src", {31'b0, out_src}, {31'b0, m_src});
    check("out_s", {22'b0, out_s}, {22'b0, m_s});
    check("out_c", {22'b0, out_c}, {22'b0, m_c});
  endtask

  logic [L-1:0] held_s, held_c;
  logic         pe_v, pf_v;
  logic [L-1:0] pe_x, pe_y, pf_x, pf_y;
  logic         ge_seen, gf_seen;

  initial begin
    rst_n = 1'b1;
    e_valid = 1'b0; f_valid = 1'b0; out_ready = 1'b0;
    e_x = '0; e_y = '0; f_x = '0; f_y = '0;
    model_reset();

    // Single E request right after reset.
    do_reset();
    step(1'b1, 10'h3FF, 10'h001, 1'b0, '0, '0, 1'b1);
    check("t1_out_s", {22'b0, out_s}, 32'h3FE);
    check("t1_out_c", {22'b0, out_c}, 32'h001);
    check("t1_out_src", {31'b0, out_src}, 32'd0);
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);

    // Continuous contention alternates starting with E.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, L'(i), L'(3 * i + 1), 1'b1, L'(7 * i), L'(i + 5), 1'b1);
      check("alt_src", {31'b0, out_src}, 32'(i % 2));
    end

    // Backpressure holds the result and keeps the fairness order.
    held_s = out_s; held_c = out_c;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10'h0F0, 10'h00F, 1'b1, 10'h333, 10'h111, 1'b0);
      check("hold_s", {22'b0, out_s}, {22'b0, held_s});
      check("hold_c", {22'b0, out_c}, {22'b0, held_c});
      check("hold_src", {31'b0, out_src}, 32'd1);
    end
    step(1'b1, 10'h0F0, 10'h00F, 1'b1, 10'h333, 10'h111, 1'b1);
    check("release_src", {31'b0, out_src}, 32'd0);

    // Single F request then drain.
    step(1'b0, '0, '0, 1'b1, 10'h155, 10'h2AA, 1'b1);
    check("t4_out_s", {22'b0, out_s}, 32'h3FF);
    check("t4_out_c", {22'b0, out_c}, 32'h000);
    check("t4_out_src", {31'b0, out_src}, 32'd1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    check("t4_drain_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while FULL.
    step(1'b0, '0, '0, 1'b1, 10'h3C3, 10'h0FF, 1'b0);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_s", {22'b0, out_s}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 10'h00A, 10'h005, 1'b1, 10'h050, 10'h0A0, 1'b1);
    check("post_rst_src", {31'b0, out_src}, 32'd0);

`ifdef HA_LANE_SCHED_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, L'(i), '1, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, L'(i), '1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    check("stat_e", {16'b0, stat_e_grants}, 32'd4);
    check("stat_f", {16'b0, stat_f_grants}, 32'd2);
    check("stat_stall", {16'b0, stat_stall}, 32'd3);
    @(negedge clk);
    e_valid = 1'b0; f_valid = 1'b0; out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("stat_stall_sat", {16'b0, stat_stall}, 32'hFFFF);
    check("stat_e_after_sat", {16'b0, stat_e_grants}, 32'd4);
`endif

    // Randomized traffic; requesters hold their pair until accepted or occasionally drop it.
    do_reset();
    pe_v = 1'b0; pf_v = 1'b0;
    pe_x = '0; pe_y = '0; pf_x = '0; pf_y = '0;
    for (int n = 0; n < 500; n++) begin
      if (!pe_v) begin
        pe_v = ($urandom_range(0, 9) < 6);
        pe_x = L'($urandom); pe_y = L'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        pe_v = 1'b0;
      end
      if (!pf_v) begin
        pf_v = ($urandom_range(0, 9) < 6);
        pf_x = L'($urandom); pf_y = L'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        pf_v = 1'b0;
      end
      step(pe_v, pe_x, pe_y, pf_v, pf_x, pf_y, ($urandom_range(0, 3) != 0));
      ge_seen = (m_valid && m_src == 1'b0 && e_ready);
      gf_seen = (m_valid && m_src == 1'b1 && f_ready);
      if (ge_seen) pe_v = 1'b0;
      if (gf_seen) pf_v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ha_lane_sched.md
# ha_lane_sched

Round-robin scheduler that shares one bank of `LANES` half-adder lanes between two requesters, E and F, which were previously hard-wired to private lane groups. Each requester offers a pair of operand vectors through a valid/ready handshake. The scheduler grants one requester per cycle and drives the shared lanes with that requester's operands. It registers the sum/carry result together with a source tag and holds it until the consumer accepts it. The block sits between the operand-producing AND stages and the downstream sum/carry consumers.

## Interface
- `LANES`, 10: number of shared half-adder lanes, which is also the operand width; legal range 1..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `e_valid` in 1: requester E has an operand pair.
- `e_x` in LANES: E operand x.
- `e_y` in LANES: E operand y.
- `e_ready` out 1: E pair accepted this cycle.
- `f_valid` in 1: requester F has an operand pair.
- `f_x` in LANES: F operand x.
- `f_y` in LANES: F operand y.
- `f_ready` out 1: F pair accepted this cycle.
- `out_valid` out 1: result register holds a result.
- `out_s` out LANES: per-lane sum, x^y.
- `out_c` out LANES: per-lane carry, x&y.
- `out_src` out 1: source of the result; 0 = E, 1 = F.
- `out_ready` in 1: consumer accepts the result.

## Operation
- Two-state FSM:
  - EMPTY: result register holds nothing.
  - FULL: result register holds a result not yet accepted.
- `can_accept` = (state==EMPTY) | (state==FULL & out_ready).
- Grant, computed combinationally and only when `can_accept` is high:
  - Only E valid: grant E.
  - Only F valid: grant F.
  - Both valid: grant the requester opposite to `last_src`.
  - Neither valid: no grant.
- `e_ready`/`f_ready` = grant to E/F. At most one ready is high per cycle; ready never asserts without the matching valid.
- On a grant:
  - The lanes compute s = x^y and c = x&y on the granted operands.
  - `out_s`, `out_c` and `out_src` load on the next edge.
  - `out_valid` goes to 1 and `last_src` updates to the granted source.
- FSM transitions:
  - EMPTY + grant → FULL.
  - FULL + out_ready + grant → FULL; back-to-back, the result is replaced.
  - FULL + out_ready + no grant → EMPTY.
  - FULL + !out_ready → FULL; outputs hold stable and both readies are 0.
- Requesters must hold valid and operands stable until ready. A requester dropping valid before ready is legal; its request is simply lost.
- Reset values:
  - State EMPTY.
  - `out_valid`=0, `out_s`=0, `out_c`=0, `out_src`=0.
  - `last_src`=1, so E wins the first contention.
  - `e_ready`/`f_ready` are 0 during reset.
- Reset asserted mid-operation discards any held result immediately, asynchronously. No partial result is ever presented.

## Timing
- Latency is one cycle: operands are accepted at edge N and the result is visible after edge N.
- Throughput is one result per cycle while `out_ready` stays high.
- Ready depends combinationally on valid, state and `out_ready`. The out_ready→in_ready path is single-level.
- Fairness: under continuous contention, grants strictly alternate E, F, E, F. Neither requester waits more than one accepted transaction.
- A stall does not advance `last_src`. Fairness order is preserved across backpressure.

## Configuration
- `HA_LANE_SCHED_STATS_EN` defined:
  - Adds outputs `stat_e_grants`, `stat_f_grants` and `stat_stall`, each 16 bits.
  - The grant counters count grants per requester.
  - `stat_stall` counts cycles with state FULL & !out_ready.
  - All three counters saturate at 0xFFFF, reset to 0, and never affect the datapath.
- Undefined: the counters and ports are absent, and behaviour is otherwise identical.

## Structure
- Package `ha_lane_sched_pkg`:
  - State enum {EMPTY, FULL}.
  - Source constants SRC_E=0, SRC_F=1.
  - Stats width constant STAT_W=16.
- Sub-module `ha_lane`: one combinational half-adder lane (s=x^y, c=x&y), instantiated `LANES` times in a generate loop.
- The FSM, arbiter and result register live in the top module.

## Test plan
- Reset, then only E valid with e_x=0x3FF and e_y=0x001, out_ready=1 → e_ready=1 in cycle 0; next cycle out_s=0x3FE, out_c=0x001, out_src=0, out_valid=1.
- E and F both valid continuously, out_ready=1 for 6 cycles → out_src sequence 0,1,0,1,0,1, with exactly one ready high each cycle.
- Result held with out_ready=0 for 3 cycles while both request → outputs stable, both readies 0. On release, the grant goes to the requester opposite the held out_src.
- Single F request of x=0x155, y=0x2AA, then no traffic → out_s=0x3FF, out_c=0x000, out_src=1. After out_ready, state returns to EMPTY and out_valid=0.
- rst_n pulsed low while FULL → out_valid drops to 0 asynchronously. After release, E wins the first contention.
- With `HA_LANE_SCHED_STATS_EN`, 4 E grants, 2 F grants and 3 stall cycles → stat_e_grants=4, stat_f_grants=2, stat_stall=3. Forcing 70000 stall cycles gives stat_stall=0xFFFF.
